uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one uart_tx serializer among NREQ byte producers. Arbitrates
//  round-robin, latches the winner's byte, pulses tx_start and waits for
//  tx_done_tick. It then acks the requester.
//  A watchdog recovers the arbiter if tx_done_tick never arrives.
//  Sits between producer FIFOs/FSMs and the uart_tx din/tx_start/tx_done_tick ports.
// PARAMETERS
//  NREQ      4        number of requesters (2..16)
//  IDX_W     2        width of grant_id, = clog2(NREQ)
//  WDOG_MAX  200000   clk cycles allowed in WAIT before timeout (>= one full frame)
//  WDOG_W    18       watchdog counter width, must hold WDOG_MAX
// PORTS
//  clk           in   1         clock
//  reset         in   1         asynchronous, active-high
//  req           in   NREQ      req[i]=1: requester i has a byte on din_bus
//  din_bus       in   8*NREQ    byte i at din_bus[8*i+7 : 8*i]
//  ack           out  NREQ      one-cycle pulse: requester i's byte fully sent
//  busy          out  1         1 whenever state != IDLE
//  grant_id      out  IDX_W     index of the current or last granted requester
//  tx_start      out  1         to uart_tx.tx_start, one-cycle pulse
//  tx_din        out  8         to uart_tx.din, held stable from START until IDLE
//  tx_done_tick  in   1         from uart_tx.tx_done_tick
//  timeout_tick  out  1         one-cycle pulse: watchdog expired, byte dropped
// BEHAVIOUR
//  - Reset values:
//    - all outputs 0, state=IDLE, wdog=0.
//    - ptr=NREQ-1, so req[0] has first priority.
//  - All outputs are registered. No combinational path from any input to any output.
//  - FSM states: IDLE -> START -> WAIT -> ACK -> IDLE. WAIT can also exit via timeout to IDLE.
//  - IDLE:
//    - If req != 0, pick the first set bit searching ptr+1, ptr+2, ... mod NREQ.
//    - Register grant_id <= winner and tx_din <= din_bus byte of the winner, then go to START.
//    - If req == 0, stay in IDLE.
//  - START: tx_start=1 for exactly this cycle, then go to WAIT with wdog=0.
//  - WAIT:
//    - wdog increments every cycle.
//    - On tx_done_tick=1: go to ACK.
//    - Else if wdog==WDOG_MAX-1: pulse timeout_tick, set ptr<=grant_id, go to IDLE. No ack.
//    - If tx_done_tick and wdog expiry coincide, tx_done_tick wins (ACK, no timeout).
//  - ACK:
//    - ack[grant_id]=1 for this cycle only; ptr<=grant_id; go to IDLE.
//  - Latency:
//    - req seen in IDLE at cycle N -> tx_start at N+1.
//    - tx_done_tick at cycle M -> ack at M+1 -> next arbitration at M+2.
//  - Requester rules:
//    - Hold req and its byte stable until ack.
//    - Deassert req in the cycle after ack unless another byte is ready.
//    - req and din_bus are sampled only in IDLE. Once granted, the transfer completes (or times out) even if req drops.
//  - tx_done_tick is ignored in IDLE, START and ACK.
//  - tx_start is never re-asserted until the previous transfer has ended in ACK or timeout.
//  - Fairness:
//    - With all req held high, grants rotate 0,1,..,NREQ-1,0,...
//    - A continuously requesting source waits at most NREQ-1 transfers.
//  - grant_id and tx_din keep their last values in IDLE. They change only on a new grant.
//  - reset asserted mid-transfer: return to reset values immediately, with no ack and no timeout pulse.
// TESTING
//  1. req=0001, din0=0xA5, model uart_tx returns tx_done_tick 10 cycles after tx_start
//     -> tx_start at N+1 with tx_din=0xA5; ack=0001 exactly one cycle after done; busy=0 after.
//  2. req=1111 held, bytes 0x10..0x13, acks answered as in test 1
//     -> grant order 0,1,2,3,0; ack pulses in the same order.
//  3. ptr=1 after a grant to 1; next req=0101 -> grant_id=2; then with req=0001 -> grant_id=0.
//  4. WDOG_MAX=16, tx_done_tick withheld
//     -> timeout_tick at the 16th WAIT cycle; no ack; next grant goes to the following requester.
//  5. tx_done_tick in the same cycle as wdog=WDOG_MAX-1 -> ack asserted, timeout_tick stays 0.
//  6. Reset pulse during WAIT -> all outputs 0 next cycle; after release req=0001 -> grant_id=0 with ptr reset.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one uart_tx serializer among NREQ byte producers. Requesters are
// served round-robin starting after the most recently served index. The
// winner's byte is latched onto tx_din, tx_start is pulsed for one cycle and
// the arbiter then waits for the serializer's tx_done_tick before acking the
// requester. A watchdog abandons the byte if tx_done_tick never arrives, so a
// wedged serializer cannot lock out every producer.
//
// Every output comes straight from a flop; nothing combinational reaches an
// output from an input.
//
// Ports
//   clk           in   1         clock
//   reset         in   1         asynchronous, active-high
//   req           in   NREQ      req[i]=1: requester i has a byte on din_bus
//   din_bus       in   8*NREQ    byte i at din_bus[8*i+7 : 8*i]
//   ack           out  NREQ      one-cycle pulse: requester i's byte fully sent
//   busy          out  1         1 whenever the arbiter is not idle
//   grant_id      out  IDX_W     index of the current or last granted requester
//   tx_start      out  1         to uart_tx.tx_start, one-cycle pulse
//   tx_din        out  8         to uart_tx.din, stable from start until idle
//   tx_done_tick  in   1         from uart_tx.tx_done_tick
//   timeout_tick  out  1         one-cycle pulse: watchdog expired, byte dropped
//
// Parameters
//   NREQ      number of requesters (2..16)
//   IDX_W     width of grant_id, equal to clog2(NREQ)
//   WDOG_MAX  cycles allowed in WAIT before giving up (>= one full frame)
//   WDOG_W    watchdog counter width, must hold WDOG_MAX
// ----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NREQ     = 4,
    parameter int IDX_W    = 2,
    parameter int WDOG_MAX = 200000,
    parameter int WDOG_W   = 18
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [8*NREQ-1:0]   din_bus,
    output logic [NREQ-1:0]     ack,
    output logic                busy,
    output logic [IDX_W-1:0]    grant_id,
    output logic                tx_start,
    output logic [7:0]          tx_din,
    input  logic                tx_done_tick,
    output logic                timeout_tick
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;

    // ptr holds the last served index; the search starts one past it.
    logic [IDX_W-1:0]    ptr;
    logic [IDX_W-1:0]    ptr_nxt;
    logic [WDOG_W-1:0]   wdog;
    logic [WDOG_W-1:0]   wdog_nxt;

    // Next values of the registered outputs.
    logic [IDX_W-1:0]    grant_id_nxt;
    logic [7:0]          tx_din_nxt;
    logic [NREQ-1:0]     ack_nxt;
    logic                busy_nxt;
    logic                tx_start_nxt;
    logic                timeout_nxt;

    // Arbitration result for the current req vector and ptr.
    logic [7:0]          din_byte [NREQ];
    logic                win_found;
    logic [IDX_W-1:0]    win_idx;
    logic                wdog_expired;

    // ------------------------------------------------------------------
    // Unpack the flat byte bus so the winner's byte is a plain array read.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            din_byte[i] = din_bus[8*i +: 8];
        end
    end

    // ------------------------------------------------------------------
    // Round-robin search: first set bit strictly above ptr wins; if there is
    // none, wrap around and take the first set bit at or below ptr. Two
    // ascending scans avoid modulo arithmetic for non-power-of-two NREQ.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable written in a combinational block gets a
        // default before any branch, so no path can leave it unassigned and
        // infer a latch.
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!win_found && req[i] && (IDX_W'(i) > ptr)) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!win_found && req[i] && (IDX_W'(i) <= ptr)) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
            end
        end
    end

    // The counter reads 0 in the first WAIT cycle, so reaching WDOG_MAX-1
    // means WDOG_MAX cycles have been spent waiting.
    assign wdog_expired = (wdog == WDOG_W'(WDOG_MAX - 1));

    // ------------------------------------------------------------------
    // Next-state and next-output logic. Outputs are computed from the state
    // being entered so that, once registered, they line up with that state.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        wdog_nxt     = wdog;
        grant_id_nxt = grant_id;
        tx_din_nxt   = tx_din;
        ack_nxt      = '0;
        timeout_nxt  = 1'b0;

        case (state)
            IDLE: begin
                // req and din_bus are only looked at here; once granted, the
                // transfer runs to ACK or timeout regardless of req.
                if (win_found) begin
                    grant_id_nxt = win_idx;
                    tx_din_nxt   = din_byte[win_idx];
                    state_nxt    = START;
                end
            end

            START: begin
                wdog_nxt  = '0;
                state_nxt = WAIT;
            end

            WAIT: begin
                wdog_nxt = wdog + WDOG_W'(1);
                // A done tick on the expiry cycle still counts as success.
                if (tx_done_tick) begin
                    ack_nxt[grant_id] = 1'b1;
                    state_nxt         = ACK;
                end else if (wdog_expired) begin
                    timeout_nxt = 1'b1;
                    ptr_nxt     = grant_id;
                    state_nxt   = IDLE;
                end
            end

            ACK: begin
                ptr_nxt   = grant_id;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt     = (state_nxt != IDLE);
        tx_start_nxt = (state_nxt == START);
    end

    // ------------------------------------------------------------------
    // State and output registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every flop samples the pre-edge values of the others.
        if (reset) begin
            state        <= IDLE;
            ptr          <= IDX_W'(NREQ - 1);
            wdog         <= '0;
            grant_id     <= '0;
            tx_din       <= '0;
            ack          <= '0;
            busy         <= 1'b0;
            tx_start     <= 1'b0;
            timeout_tick <= 1'b0;
        end else begin
            state        <= state_nxt;
            ptr          <= ptr_nxt;
            wdog         <= wdog_nxt;
            grant_id     <= grant_id_nxt;
            tx_din       <= tx_din_nxt;
            ack          <= ack_nxt;
            busy         <= busy_nxt;
            tx_start     <= tx_start_nxt;
            timeout_tick <= timeout_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Interface invariants.
    // ------------------------------------------------------------------
    a_ack_onehot : assert property (@(posedge clk) disable iff (reset)
        $onehot0(ack));

    a_ack_xor_timeout : assert property (@(posedge clk) disable iff (reset)
        !((|ack) && timeout_tick));

    a_start_pulse : assert property (@(posedge clk) disable iff (reset)
        tx_start |=> !tx_start);

endmodule
